// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like arbiter: transfer size encodings,
// arbitration mode selectors and the arbiter state encoding.
package sram_like_arbiter_pkg;

  // Transfer size encodings carried on m_size / s_size
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Arbitration mode selectors for ARB_MODE
  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of channel IDs for accepted-but-unanswered transactions.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   push, din    enqueue an ID (ignored when full)
//   pop          dequeue the head ID (ignored when empty)
//   dout         head ID
//   full, empty  occupancy flags
module sram_like_arbiter_id_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap naturally on overflow
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel sram-like arbiter: merges NUM_CH masters onto one slave port.
// Fixed-priority or round-robin pick; a pending (not yet accepted) slave
// request is locked to its channel; an in-order ID FIFO routes responses.
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   m_req/m_wr/m_size/m_addr/m_wstrb/m_wdata  packed per-channel requests
//   m_addr_ok, m_data_ok, m_rdata       per-channel handshakes, shared rdata
//   s_req/s_wr/s_size/s_addr/s_wstrb/s_wdata  slave request payload
//   s_addr_ok, s_data_ok, s_rdata       slave handshakes and read data
//   proto_err                           sticky: data_ok with nothing outstanding
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned OT_DEPTH = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            m_req,
  input  logic [NUM_CH-1:0]            m_wr,
  input  logic [2*NUM_CH-1:0]          m_size,
  input  logic [ADDR_W*NUM_CH-1:0]     m_addr,
  input  logic [(DATA_W/8)*NUM_CH-1:0] m_wstrb,
  input  logic [DATA_W*NUM_CH-1:0]     m_wdata,
  output logic [NUM_CH-1:0]            m_addr_ok,
  output logic [NUM_CH-1:0]            m_data_ok,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         s_req,
  output logic                         s_wr,
  output logic [1:0]                   s_size,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W/8-1:0]          s_wstrb,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic                         s_addr_ok,
  input  logic                         s_data_ok,
  input  logic [DATA_W-1:0]            s_rdata,
  output logic                         proto_err
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_e      state_q, state_d;
  logic [CH_W-1:0] lock_ch_q, lock_ch_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            proto_err_q;

  logic [CH_W-1:0] pick, grant, head;
  logic [CH_W-1:0] idx;
  logic            pick_vld, sel_vld, accept, pop;
  logic            fifo_full, fifo_empty;

  // Combinational pick: fixed scans from 0, round-robin scans from rr_ptr
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == ARB_RR) idx = CH_W'((i + 32'(rr_ptr_q)) % NUM_CH);
      else                    idx = CH_W'(i);
      if (!pick_vld && m_req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  assign grant = (state_q == ARB_LOCK) ? lock_ch_q : pick;
  // resetn gates the selection so outputs are quiet while reset is held
  assign sel_vld = resetn && ((state_q == ARB_LOCK) || pick_vld);
  assign s_req   = sel_vld && !fifo_full;
  assign accept  = s_req && s_addr_ok;
  assign pop     = s_data_ok && !fifo_empty;
  assign m_rdata = s_rdata;
  assign proto_err = proto_err_q;

  always_comb begin
    s_wr      = 1'b0;
    s_size    = '0;
    s_addr    = '0;
    s_wstrb   = '0;
    s_wdata   = '0;
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel_vld && (grant == CH_W'(i))) begin
        s_wr    = m_wr[i];
        s_size  = m_size[i*2 +: 2];
        s_addr  = m_addr[i*ADDR_W +: ADDR_W];
        s_wstrb = m_wstrb[i*STRB_W +: STRB_W];
        s_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
      m_addr_ok[i] = accept && (grant == CH_W'(i));
      m_data_ok[i] = pop && (head == CH_W'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (s_req && !s_addr_ok) begin
          state_d   = ARB_LOCK;
          lock_ch_d = grant;
        end
      end
      ARB_LOCK: begin
        if (accept) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (accept && (ARB_MODE == ARB_RR)) rr_ptr_d = CH_W'((32'(grant) + 1) % NUM_CH);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ARB_IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      if (s_data_ok && fifo_empty) proto_err_q <= 1'b1;
    end
  end

  sram_like_arbiter_id_fifo #(
    .WIDTH (CH_W),
    .DEPTH (OT_DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (pop),
    .din    (grant),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NCH-1:0]    m_req, m_wr;
  logic [2*NCH-1:0]  m_size;
  logic [AW*NCH-1:0] m_addr;
  logic [4*NCH-1:0]  m_wstrb;
  logic [DW*NCH-1:0] m_wdata;
  logic              s_addr_ok, s_data_ok;
  logic [DW-1:0]     s_rdata;

  // Round-robin instance
  logic [NCH-1:0] m_addr_ok, m_data_ok;
  logic [DW-1:0]  m_rdata, s_addr, s_wdata;
  logic           s_req, s_wr, proto_err;
  logic [1:0]     s_size;
  logic [3:0]     s_wstrb;

  // Fixed-priority instance, same stimulus
  logic [NCH-1:0] fx_m_addr_ok, fx_m_data_ok;
  logic [DW-1:0]  fx_m_rdata, fx_s_addr, fx_s_wdata;
  logic           fx_s_req, fx_s_wr, fx_proto_err;
  logic [1:0]     fx_s_size;
  logic [3:0]     fx_s_wstrb;

  int errors = 0;
  int checks = 0;
  int sb[$];  // expected responding channel, in acceptance order

  always #5 clk = ~clk;

  sram_like_arbiter #(
    .NUM_CH(NCH), .OT_DEPTH(4), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)
  ) dut (
    .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata), .s_req(s_req), .s_wr(s_wr),
    .s_size(s_size), .s_addr(s_addr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .proto_err(proto_err)
  );

  sram_like_arbiter #(
    .NUM_CH(NCH), .OT_DEPTH(4), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)
  ) dut_fx (
    .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_addr_ok(fx_m_addr_ok),
    .m_data_ok(fx_m_data_ok), .m_rdata(fx_m_rdata), .s_req(fx_s_req), .s_wr(fx_s_wr),
    .s_size(fx_s_size), .s_addr(fx_s_addr), .s_wstrb(fx_s_wstrb), .s_wdata(fx_s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .proto_err(fx_proto_err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_req = '0; m_wr = '0; m_size = '0; m_addr = '0; m_wstrb = '0; m_wdata = '0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    resetn = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    next_cycle();
  endtask

  // Present a request on one channel with an eager slave; record the accept
  task automatic issue(input int ch, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bit done;
    done = 1'b0;
    m_req[ch] = 1'b1; m_wr[ch] = wr; m_size[ch*2 +: 2] = 2'd2;
    m_addr[ch*AW +: AW] = addr; m_wdata[ch*DW +: DW] = wdata; m_wstrb[ch*4 +: 4] = 4'hf;
    s_addr_ok = 1'b1;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (m_addr_ok[ch]) begin
        done = 1'b1;
        sb.push_back(ch);
        checks++;
        if (s_addr !== addr || s_wr !== wr || s_size !== 2'd2 || (wr && s_wdata !== wdata)) begin
          errors++;
          $display("FAIL issue_payload ch%0d got addr=%h wr=%b size=%0d wdata=%h exp addr=%h wr=%b",
                   ch, s_addr, s_wr, s_size, s_wdata, addr, wr);
        end
      end
      next_cycle();
    end
    m_req[ch] = 1'b0;
    s_addr_ok = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout ch%0d got no m_addr_ok exp accept within 10 cycles", ch);
    end
  endtask

  // Slave returns one response; scoreboard says which channel must see it
  task automatic respond(input logic [31:0] data);
    int exp_ch;
    s_data_ok = 1'b1; s_rdata = data;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL respond_sb_empty got m_data_ok=%b exp an outstanding entry", m_data_ok);
    end else begin
      exp_ch = sb.pop_front();
      if (m_data_ok !== 2'(1 << exp_ch) || m_rdata !== data) begin
        errors++;
        $display("FAIL respond got data_ok=%b rdata=%h exp data_ok=%b rdata=%h",
                 m_data_ok, m_rdata, 2'(1 << exp_ch), data);
      end
    end
    next_cycle();
    s_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    m_req = 2'b11; s_addr_ok = 1'b1;
    #2;
    checks++;
    if (s_req !== 1'b0 || m_addr_ok !== 2'b00 || m_data_ok !== 2'b00 || proto_err !== 1'b0
        || s_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs got s_req=%b addr_ok=%b data_ok=%b perr=%b s_addr=%h exp 0",
               s_req, m_addr_ok, m_data_ok, proto_err, s_addr);
    end
    reset_dut();
    @(negedge clk);
    checks++;
    if (s_req !== 1'b0 || m_addr_ok !== 2'b00 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got s_req=%b addr_ok=%b perr=%b exp 0 0 0",
               s_req, m_addr_ok, proto_err);
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    reset_dut();
    m_req = 2'b01; m_addr[31:0] = 32'h1000; s_addr_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (m_addr_ok !== 2'b01 || s_req !== 1'b1 || s_addr !== 32'h1000) begin
      errors++;
      $display("FAIL single_accept got addr_ok=%b s_req=%b s_addr=%h exp 01 1 00001000",
               m_addr_ok, s_req, s_addr);
    end
    if (m_addr_ok === 2'b01) sb.push_back(0);
    next_cycle();
    m_req = '0; s_addr_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (m_data_ok !== 2'b00) begin
      errors++;
      $display("FAIL single_early_data got data_ok=%b exp 00", m_data_ok);
    end
    next_cycle();
    respond(32'hDEADBEEF);
  endtask

  task automatic test_arbitration();
    int exp_rr[4] = '{0, 1, 0, 1};
    reset_dut();
    m_req = 2'b11; s_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (m_addr_ok !== 2'(1 << exp_rr[k]) || fx_m_addr_ok !== 2'b01) begin
        errors++;
        $display("FAIL arb_grant%0d got rr=%b fixed=%b exp rr=%b fixed=01",
                 k, m_addr_ok, fx_m_addr_ok, 2'(1 << exp_rr[k]));
      end
      next_cycle();
    end
    m_req = '0; s_addr_ok = 1'b0;
  endtask

  task automatic test_stall_lock();
    reset_dut();
    m_req = 2'b10; m_addr[63:32] = 32'h2000; m_addr[31:0] = 32'h3000;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) m_req = 2'b11;
      @(negedge clk);
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h2000 || fx_s_addr !== 32'h2000
          || m_addr_ok !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold%0d got s_req=%b s_addr=%h fx_addr=%h addr_ok=%b exp 1 2000 2000 00",
                 k, s_req, s_addr, fx_s_addr, m_addr_ok);
      end
      next_cycle();
    end
    s_addr_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (m_addr_ok !== 2'b10) begin
      errors++;
      $display("FAIL stall_accept got addr_ok=%b exp 10", m_addr_ok);
    end else sb.push_back(1);
    next_cycle();
    m_req = 2'b01;
    @(negedge clk);
    checks++;
    if (m_addr_ok !== 2'b01 || s_addr !== 32'h3000) begin
      errors++;
      $display("FAIL stall_next got addr_ok=%b s_addr=%h exp 01 3000", m_addr_ok, s_addr);
    end else sb.push_back(0);
    next_cycle();
    m_req = '0; s_addr_ok = 1'b0;
    respond(32'hAA);
    respond(32'hBB);
  endtask

  task automatic test_interleaved();
    reset_dut();
    issue(0, 1'b0, 32'h100, 32'h0);
    issue(1, 1'b1, 32'h200, 32'hCAFE);
    issue(0, 1'b0, 32'h300, 32'h0);
    respond(32'h11);
    respond(32'h22);
    respond(32'h33);
  endtask

  task automatic test_full();
    reset_dut();
    m_req = 2'b01; m_addr[31:0] = 32'h40; s_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (m_addr_ok !== 2'b01) begin
        errors++;
        $display("FAIL full_fill%0d got addr_ok=%b exp 01", k, m_addr_ok);
      end else sb.push_back(0);
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (s_req !== 1'b0 || m_addr_ok !== 2'b00) begin
      errors++;
      $display("FAIL full_block got s_req=%b addr_ok=%b exp 0 00", s_req, m_addr_ok);
    end
    next_cycle();
    // Pop while full: request must still be held off this cycle
    s_data_ok = 1'b1; s_rdata = 32'hA0;
    @(negedge clk);
    checks++;
    if (s_req !== 1'b0 || m_addr_ok !== 2'b00) begin
      errors++;
      $display("FAIL full_no_bypass got s_req=%b addr_ok=%b exp 0 00", s_req, m_addr_ok);
    end
    checks++;
    if (m_data_ok !== 2'b01 || m_rdata !== 32'hA0) begin
      errors++;
      $display("FAIL full_pop got data_ok=%b rdata=%h exp 01 a0", m_data_ok, m_rdata);
    end
    void'(sb.pop_front());
    next_cycle();
    s_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (s_req !== 1'b1 || m_addr_ok !== 2'b01) begin
      errors++;
      $display("FAIL full_resume got s_req=%b addr_ok=%b exp 1 01", s_req, m_addr_ok);
    end else sb.push_back(0);
    next_cycle();
    m_req = '0; s_addr_ok = 1'b0;
    for (int k = 0; k < 4; k++) respond(32'hB0 + 32'(k));
  endtask

  task automatic test_reset_error();
    reset_dut();
    issue(0, 1'b0, 32'h500, 32'h0);
    issue(1, 1'b0, 32'h600, 32'h0);
    m_req = 2'b11; s_addr_ok = 1'b1; s_data_ok = 1'b1;
    resetn = 1'b0;
    #1;
    checks++;
    if (s_req !== 1'b0 || m_addr_ok !== 2'b00 || m_data_ok !== 2'b00 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset got s_req=%b addr_ok=%b data_ok=%b perr=%b exp 0 00 00 0",
               s_req, m_addr_ok, m_data_ok, proto_err);
    end
    sb.delete();
    clear_inputs();
    next_cycle();
    resetn = 1'b1;
    next_cycle();
    s_data_ok = 1'b1; s_rdata = 32'h77;
    @(negedge clk);
    checks++;
    if (m_data_ok !== 2'b00 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL stray_data got data_ok=%b perr=%b exp 00 0", m_data_ok, proto_err);
    end
    next_cycle();
    s_data_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (proto_err !== 1'b1) begin
        errors++;
        $display("FAIL proto_err_sticky%0d got %b exp 1", k, proto_err);
      end
      next_cycle();
    end
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    test_reset();
    test_single_read();
    test_arbitration();
    test_stall_lock();
    test_interleaved();
    test_full();
    test_reset_error();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d entries exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
